// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the memory bus arbiter.
package mem_arb_pkg;
  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {ARB_IDLE, ARB_REQUEST, ARB_WAIT_RESP} arb_state;
  typedef enum logic {OWNER_FETCH, OWNER_EXEC} arb_owner;
endpackage

// File: rtl/mem_bus_arbiter_timeout.sv
// Watchdog for one bus transaction: counts cycles while enabled, flags the last allowed cycle.
module bus_timeout_counter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) count <= '0;
    else if (enable)    count <= count + CW'(1);
  end

  // High on the edge that would make the count reach TIMEOUT_CYCLES.
  assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch / execute) arbiter for the core memory bus, one transaction at a time.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate grants on contention instead of execute-first.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    f_req,
  input  logic [ADDR_WIDTH-1:0]   f_addr,
  input  logic                    f_abort,
  output logic                    f_ack,
  output logic                    f_done,
  output logic [DATA_WIDTH-1:0]   f_rdata,
  output logic                    f_error,
  input  logic                    e_req,
  input  logic [ADDR_WIDTH-1:0]   e_addr,
  input  logic                    e_write,
  input  logic [DATA_WIDTH-1:0]   e_wdata,
  input  logic [DATA_WIDTH/8-1:0] e_strb,
  output logic                    e_ack,
  output logic                    e_done,
  output logic [DATA_WIDTH-1:0]   e_rdata,
  output logic                    e_error,
  output logic                    m_valid,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic                    m_write,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_strb,
  input  logic                    m_ready,
  input  logic                    m_done,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic                    m_error,
  output logic                    owner,
  output arb_state                state
);
  // Bus handshake: the request transfers on a cycle with m_valid && m_ready; m_* stay frozen
  // while m_valid is high without m_ready. m_done only counts once the request has transferred
  // (same cycle as m_ready included).
  arb_owner              owner_q;
  logic                  discard;
  logic                  busy, f_valid, grant_any, grant_exec;
  logic                  bus_done, expired, finish, abort_hit;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_error;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_owner              last_owner;
`endif

  assign busy       = (state != ARB_IDLE);
  assign f_valid    = f_req && !f_abort;
  assign grant_any  = f_valid || e_req;
  assign bus_done   = ((state == ARB_REQUEST) && m_ready && m_done) ||
                      ((state == ARB_WAIT_RESP) && m_done);
  assign finish     = bus_done || expired;
  assign resp_data  = bus_done ? m_rdata : '0;
  assign resp_error = bus_done ? m_error : 1'b1;
  assign abort_hit  = busy && f_abort && (owner_q == OWNER_FETCH);
  assign owner      = (owner_q == OWNER_EXEC);

  always_comb begin
    grant_exec = e_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (e_req && f_valid) grant_exec = (last_owner == OWNER_FETCH);
`endif
  end

  bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (!busy),
    .enable  (busy),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ARB_IDLE;
      owner_q <= OWNER_FETCH;
      discard <= 1'b0;
      f_ack   <= 1'b0;
      f_done  <= 1'b0;
      f_rdata <= '0;
      f_error <= 1'b0;
      e_ack   <= 1'b0;
      e_done  <= 1'b0;
      e_rdata <= '0;
      e_error <= 1'b0;
      m_valid <= 1'b0;
      m_addr  <= '0;
      m_write <= 1'b0;
      m_wdata <= '0;
      m_strb  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_owner <= OWNER_FETCH;
`endif
    end else begin
      f_ack  <= 1'b0;
      e_ack  <= 1'b0;
      f_done <= 1'b0;
      e_done <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_any) begin
            state   <= ARB_REQUEST;
            m_valid <= 1'b1;
            if (grant_exec) begin
              owner_q <= OWNER_EXEC;
              m_addr  <= e_addr;
              m_write <= e_write;
              m_wdata <= e_wdata;
              m_strb  <= e_strb;
              e_ack   <= 1'b1;
            end else begin
              owner_q <= OWNER_FETCH;
              m_addr  <= f_addr;
              m_write <= 1'b0;
              m_wdata <= '0;
              m_strb  <= '0;
              f_ack   <= 1'b1;
            end
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_owner <= grant_exec ? OWNER_EXEC : OWNER_FETCH;
`endif
          end
        end
        ARB_REQUEST, ARB_WAIT_RESP: begin
          if (abort_hit) discard <= 1'b1;
          if (finish) begin
            state   <= ARB_IDLE;
            m_valid <= 1'b0;
            owner_q <= OWNER_FETCH;
            discard <= 1'b0;
            if (owner_q == OWNER_EXEC) begin
              e_done  <= 1'b1;
              e_rdata <= resp_data;
              e_error <= resp_error;
            end else if (!(discard || abort_hit)) begin
              // A flushed fetch still drains on the bus but its response is dropped here.
              f_done  <= 1'b1;
              f_rdata <= resp_data;
              f_error <= resp_error;
            end
          end else if ((state == ARB_REQUEST) && m_ready) begin
            state   <= ARB_WAIT_RESP;
            m_valid <= 1'b0;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed plus randomized bench for mem_bus_arbiter against a transaction-level model.
module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          f_req, f_abort, f_ack, f_done, f_error;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_rdata;
  logic          e_req, e_write, e_ack, e_done, e_error;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;
  logic [3:0]    e_strb;
  logic          m_valid, m_write, m_ready, m_done, m_error;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [3:0]    m_strb;
  logic          owner;
  arb_state      state;

  int total = 0;
  int bad   = 0;

  // Model state: last granted requester and the last delivered fetch response.
  bit            m_last;
  logic [DW-1:0] mf_rdata;
  logic          mf_error;
  logic [DW:0]   exp_q[$];

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_abort(f_abort), .f_ack(f_ack), .f_done(f_done),
    .f_rdata(f_rdata), .f_error(f_error),
    .e_req(e_req), .e_addr(e_addr), .e_write(e_write), .e_wdata(e_wdata), .e_strb(e_strb),
    .e_ack(e_ack), .e_done(e_done), .e_rdata(e_rdata), .e_error(e_error),
    .m_valid(m_valid), .m_addr(m_addr), .m_write(m_write), .m_wdata(m_wdata), .m_strb(m_strb),
    .m_ready(m_ready), .m_done(m_done), .m_rdata(m_rdata), .m_error(m_error),
    .owner(owner), .state(state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] outs();
    return {f_ack, f_done, f_rdata, f_error, e_ack, e_done, e_rdata, e_error,
            m_valid, m_addr, m_write, m_wdata, m_strb, owner};
  endfunction

  task automatic model_reset();
    m_last   = 1'b0;
    mf_rdata = '0;
    mf_error = 1'b0;
    exp_q.delete();
  endtask

  // One grant-to-completion transaction. r: cycles before m_ready; d: cycles from m_ready to
  // m_done (0 = same cycle); hang: bus never completes; abort_en/a: flush a fetch at offset a.
  task automatic serve(input int r, input int d, input bit hang, input bit abort_en, input int a,
                       input logic [DW-1:0] rd, input bit er, input bit raise_e);
    bit            win_e, sup;
    int            lat, len, ab, k;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wdata;
    logic          x_write;
    logic [3:0]    x_strb;
    logic [DW:0]   resp;
    if (e_req && f_req && !f_abort) win_e = RR ? !m_last : 1'b1;
    else                            win_e = e_req;
    m_last = win_e;
    if (win_e) begin
      x_addr = e_addr; x_write = e_write; x_wdata = e_wdata; x_strb = e_strb;
    end else begin
      x_addr = f_addr; x_write = 1'b0; x_wdata = '0; x_strb = '0;
    end
    lat = r + 1 + d;
    len = (hang || lat > TMO) ? TMO : lat;
    sup = !win_e && abort_en && (len >= 2);
    ab  = (len >= 2) ? (a % (len - 1)) : 0;
    if (!sup) exp_q.push_back((hang || lat > TMO) ? {1'b1, {DW{1'b0}}} : {er, rd});

    tick();
    check("grant_flags", {f_ack, e_ack, f_done, e_done, m_valid, owner},
          {!win_e, win_e, 1'b0, 1'b0, 1'b1, win_e});
    check("grant_payload", {m_addr, m_write, m_wdata, m_strb}, {x_addr, x_write, x_wdata, x_strb});
    if (win_e) e_req = 1'b0; else f_req = 1'b0;
    if (raise_e) e_req = 1'b1;

    for (int j = 0; j < len; j++) begin
      m_ready = (j == r);
      m_done  = !hang && (j == r + d);
      m_rdata = rd;
      m_error = er;
      f_abort = sup && (j == ab);
      tick();
      k = j + 1;
      check("cycle_flags", {f_ack, e_ack, f_done, e_done, m_valid, owner},
            {1'b0, 1'b0, (k == len) && !win_e && !sup, (k == len) && win_e,
             (k <= r) && (k < len), win_e && (k < len)});
      if ((k <= r) && (k < len)) check("hold_addr", m_addr, x_addr);
    end
    m_ready = 1'b0;
    m_done  = 1'b0;
    f_abort = 1'b0;
    m_rdata = $urandom;

    if (sup) begin
      check("abort_keeps_fetch_resp", {f_error, f_rdata}, {mf_error, mf_rdata});
    end else begin
      resp = exp_q.pop_front();
      if (win_e) begin
        check("exec_resp", {e_error, e_rdata}, resp);
      end else begin
        check("fetch_resp", {f_error, f_rdata}, resp);
        {mf_error, mf_rdata} = resp;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    f_req = 0; f_addr = '0; f_abort = 0;
    e_req = 0; e_addr = '0; e_write = 0; e_wdata = '0; e_strb = '0;
    m_ready = 0; m_done = 0; m_rdata = '0; m_error = 0;
    model_reset();
    repeat (2) tick();
    check("reset_outputs", outs(), '0);
    check("reset_state", state, ARB_IDLE);
    reset = 1'b0;
    tick();

    // Fetch alone.
    f_addr = 32'h100; f_req = 1'b1;
    serve(0, 3, 0, 0, 0, 32'hDEADBEEF, 0, 0);

    // A fetch raised together with a flush is not taken.
    f_addr = 32'h140; f_req = 1'b1; f_abort = 1'b1;
    tick();
    check("abort_blocks_req", {f_ack, e_ack, m_valid}, 3'b000);
    f_abort = 1'b0;
    serve(1, 1, 0, 0, 0, 32'hCAFE0001, 1, 0);

    // Contention, twice.
    for (int p = 0; p < 2; p++) begin
      f_addr = 32'h300; f_req = 1'b1;
      e_addr = 32'h200; e_write = 1'b1; e_wdata = 32'h12345678; e_strb = 4'hF; e_req = 1'b1;
      serve(0, 1, 0, 0, 0, 32'h0, 0, 0);
      serve(1, 0, 0, 0, 0, 32'hA5A50000 + p, 0, 0);
    end

    // Backpressure: m_ready low for 5 cycles.
    e_addr = 32'h400; e_write = 1'b0; e_strb = 4'h3; e_req = 1'b1;
    serve(5, 2, 0, 0, 0, 32'h0BADF00D, 0, 0);

    // Timeout after acceptance, then a late m_done that must be ignored.
    e_addr = 32'h480; e_req = 1'b1;
    serve(1, 0, 1, 0, 0, 32'h77777777, 0, 0);
    m_done = 1'b1; m_rdata = 32'hBAD0BAD0;
    tick();
    m_done = 1'b0;
    check("late_done_ignored", {f_done, e_done, m_valid, e_error, e_rdata}, {4'b0001, 32'h0});
    // Timeout while never accepted, then normal traffic; then a real done on the deadline cycle.
    f_addr = 32'h4C0; f_req = 1'b1;
    serve(100, 0, 1, 0, 0, 32'h1, 0, 0);
    e_addr = 32'h500; e_req = 1'b1;
    serve(0, 0, 0, 0, 0, 32'h13572468, 0, 0);
    f_addr = 32'h540; f_req = 1'b1;
    serve(3, TMO - 4, 0, 0, 0, 32'h2468ACE0, 0, 0);

    // Flush during the response wait, with an execute request queued behind it.
    f_addr = 32'h580; f_req = 1'b1;
    e_addr = 32'h5C0; e_write = 1'b1; e_wdata = 32'h55AA55AA; e_strb = 4'hC;
    serve(0, 4, 0, 1, 1, 32'hFFFF0000, 0, 1);
    serve(0, 1, 0, 0, 0, 32'h0, 0, 0);

    // Reset in the middle of a response wait.
    e_addr = 32'h600; e_req = 1'b1;
    tick();
    e_req = 1'b0; m_ready = 1'b1;
    tick();
    m_ready = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check("midreset_outputs", outs(), '0);
    m_done = 1'b1; m_rdata = 32'h99999999;
    tick();
    m_done = 1'b0;
    check("midreset_late_done", {f_done, e_done, m_valid, e_rdata}, '0);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      int mode;
      mode    = $urandom_range(0, 2);
      f_addr  = $urandom;
      e_addr  = $urandom;
      e_write = 1'($urandom_range(0, 1));
      e_wdata = $urandom;
      e_strb  = 4'($urandom_range(0, 15));
      f_req   = (mode != 1);
      e_req   = (mode != 0);
      serve($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom, 1'($urandom_range(0, 1)), 0);
      if (f_req || e_req)
        serve($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom, 1'($urandom_range(0, 1)), 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
